// File: rtl/bpu_ras_if.sv
// bpu_ras_if: predictor-side port bundle for the return address stack.
// master = predictor (drives push/pop/flush/checkpoint), slave = RAS.
interface bpu_ras_if #(
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
);
  logic             push;
  logic [31:0]      push_addr;
  logic             pop;
  logic             flush;
  logic             ckpt_save;
  logic             ckpt_restore;
  logic [32:0]      top;    // {valid, data}
  logic [CNT_W-1:0] count;

  modport master (
    output push, push_addr, pop, flush, ckpt_save, ckpt_restore,
    input  top, count
  );

  modport slave (
    input  push, push_addr, pop, flush, ckpt_save, ckpt_restore,
    output top, count
  );
endinterface

// File: rtl/bpu_ras.sv
// bpu_ras: circular return address stack beside pre_IF.
// Calls push PC+8, returns pop and expose the predicted target on top.
// When full, a push overwrites the oldest entry. Optional pointer
// checkpoint/restore is compiled in with RAS_CHECKPOINT_EN; without it
// ckpt_restore acts as a flush and ckpt_save is ignored.
module bpu_ras #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input logic      clk,
  input logic      resetn,
  bpu_ras_if.slave bus
);
  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

  logic [31:0]      ent_data_q [DEPTH];
  logic [DEPTH-1:0] ent_vld_q;
  logic [PTR_W-1:0] sp_q, sp_d, sp_top, wr_idx;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             wr_en, clr_top, clr_all;
  logic             do_flush, do_restore;
  logic [PTR_W-1:0] ck_sp;
  logic [PTR_W:0]   ck_cnt;

  // Per-entry valid bits are kept as part of the stack image but the
  // visible valid comes from the occupancy count, so nothing reads them.
  logic unused_ent_vld;
  assign unused_ent_vld = ^ent_vld_q;

  assign sp_top    = sp_q - PTR_W'(1);
  assign bus.count = cnt_q;
  assign bus.top   = (cnt_q != '0) ? {1'b1, ent_data_q[sp_top]} : 33'd0;

`ifdef RAS_CHECKPOINT_EN
  logic [PTR_W-1:0] ck_sp_q;
  logic [PTR_W:0]   ck_cnt_q;

  assign do_flush   = bus.flush;
  assign do_restore = bus.ckpt_restore;
  assign ck_sp      = ck_sp_q;
  assign ck_cnt     = ck_cnt_q;

  // Capture pointer/count; a coincident restore reloads the checkpoint,
  // which is then the value that stays saved.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ck_sp_q  <= '0;
      ck_cnt_q <= '0;
    end else if (bus.ckpt_save && !bus.ckpt_restore) begin
      ck_sp_q  <= sp_q;
      ck_cnt_q <= cnt_q;
    end
  end
`else
  logic unused_ckpt_save;
  assign unused_ckpt_save = bus.ckpt_save;

  assign do_flush   = bus.flush | bus.ckpt_restore;
  assign do_restore = 1'b0;
  assign ck_sp      = '0;
  assign ck_cnt     = '0;
`endif

  // Next pointer/count and entry write selection: flush > restore > push/pop.
  always_comb begin
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = sp_q;
    clr_top = 1'b0;
    clr_all = 1'b0;
    if (do_flush) begin
      clr_all = 1'b1;
      sp_d    = '0;
      cnt_d   = '0;
    end else if (do_restore) begin
      sp_d  = ck_sp;
      cnt_d = ck_cnt;
    end else if (bus.push && bus.pop && cnt_q != '0) begin
      // call+return in one cycle: net effect is replacing the top
      wr_en  = 1'b1;
      wr_idx = sp_top;
    end else if (bus.push) begin
      wr_en = 1'b1;
      sp_d  = sp_q + PTR_W'(1);
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + (PTR_W+1)'(1);
    end else if (bus.pop && cnt_q != '0) begin
      clr_top = 1'b1;
      sp_d    = sp_top;
      cnt_d   = cnt_q - (PTR_W+1)'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; flush only drops valid bits, data is left in place.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) ent_data_q[i] <= '0;
      ent_vld_q <= '0;
    end else if (clr_all) begin
      ent_vld_q <= '0;
    end else if (wr_en) begin
      ent_data_q[wr_idx] <= bus.push_addr;
      ent_vld_q[wr_idx]  <= 1'b1;
    end else if (clr_top) begin
      ent_vld_q[sp_top] <= 1'b0;
    end
  end
endmodule
